// File: rtl/param_data_transfer_pipe_pkg.sv
// Shared constants and helpers for the parametrised transfer pipe.
// Mode encodings plus a popcount used to derive the occupancy count.
package param_data_transfer_pipe_pkg;

   localparam logic MODE_SHIFT = 1'b0;
   localparam logic MODE_BCAST = 1'b1;

   // Widest valid vector popcount accepts; callers zero-extend into it.
   localparam int POP_MAX_W = 256;

   function automatic logic [8:0] popcount(input logic [POP_MAX_W-1:0] v);
      logic [8:0] c;
      c = '0;
      for (int i = 0; i < POP_MAX_W; i++) c = c + {8'd0, v[i]};
      return c;
   endfunction

endpackage

// File: rtl/param_data_transfer_pipe_stage.sv
// One register stage with its valid bit: async reset, sync flush, load enable.
module transfer_stage #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             d_valid,
   output logic [WIDTH-1:0] q,
   output logic             q_valid
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q       <= '0;
         q_valid <= 1'b0;
      end else if (flush) begin
         q       <= '0;
         q_valid <= 1'b0;
      end else if (load) begin
         q       <= d;
         q_valid <= d_valid;
      end
   end

endmodule

// File: rtl/param_data_transfer_pipe.sv
// DEPTH-stage register chain acting as a delay line (shift) or tap bank (broadcast),
// with per-stage valid bits and a registered occupancy count.
module param_data_transfer_pipe
   import param_data_transfer_pipe_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   mode,
   input  logic                   flush,
   input  logic                   in_valid,
   input  logic [WIDTH-1:0]       data_in,
   output logic [WIDTH*DEPTH-1:0] taps,
   output logic [DEPTH-1:0]       taps_valid,
   output logic [WIDTH-1:0]       data_out,
   output logic                   out_valid,
   output logic [CNT_W-1:0]       fill_cnt
);

   logic [DEPTH-1:0][WIDTH-1:0] stage_q;
   logic [DEPTH-1:0][WIDTH-1:0] stage_d;
   logic [DEPTH-1:0]            valid_q;
   logic [DEPTH-1:0]            valid_d;
   logic [DEPTH-1:0]            valid_nxt;
   logic [POP_MAX_W-1:0]        valid_ext;

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      if (g == 0) begin : g_head
         assign stage_d[g] = data_in;
         assign valid_d[g] = in_valid;
      end else begin : g_body
         assign stage_d[g] = (mode == MODE_BCAST) ? data_in  : stage_q[g-1];
         assign valid_d[g] = (mode == MODE_BCAST) ? in_valid : valid_q[g-1];
      end

      transfer_stage #(.WIDTH(WIDTH)) u_stage (
         .clk     (clk),
         .rst     (rst),
         .flush   (flush),
         .load    (en),
         .d       (stage_d[g]),
         .d_valid (valid_d[g]),
         .q       (stage_q[g]),
         .q_valid (valid_q[g])
      );
   end

   // Mirror the stages' next valid vector so fill_cnt lands on the same edge.
   always_comb begin
      valid_nxt = valid_q;
      if (flush)   valid_nxt = '0;
      else if (en) valid_nxt = valid_d;
      valid_ext = '0;
      valid_ext[DEPTH-1:0] = valid_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) fill_cnt <= '0;
      else     fill_cnt <= CNT_W'(popcount(valid_ext));
   end

   assign taps       = stage_q;
   assign taps_valid = valid_q;
   assign data_out   = stage_q[DEPTH-1];
   assign out_valid  = valid_q[DEPTH-1];

endmodule

// File: tb/tb_param_data_transfer_pipe.sv
// Self-checking bench: vector table on a 4x2 instance, scoreboard on an 8x4 instance.
module tb_param_data_transfer_pipe;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // WIDTH=4, DEPTH=2 instance
   logic       en, mode, flush, in_valid;
   logic [3:0] data_in, data_out;
   logic [7:0] taps;
   logic [1:0] taps_valid, fill_cnt;
   logic       out_valid;

   // WIDTH=8, DEPTH=4 instance
   logic       en4, mode4, flush4, iv4;
   logic [7:0] din4, dout4;
   logic [31:0] taps4;
   logic [3:0] tv4;
   logic [2:0] cnt4;
   logic       ov4;

   param_data_transfer_pipe #(.WIDTH(4), .DEPTH(2)) dut2 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .flush(flush), .in_valid(in_valid),
      .data_in(data_in), .taps(taps), .taps_valid(taps_valid), .data_out(data_out),
      .out_valid(out_valid), .fill_cnt(fill_cnt)
   );

   param_data_transfer_pipe #(.WIDTH(8), .DEPTH(4)) dut4 (
      .clk(clk), .rst(rst), .en(en4), .mode(mode4), .flush(flush4), .in_valid(iv4),
      .data_in(din4), .taps(taps4), .taps_valid(tv4), .data_out(dout4),
      .out_valid(ov4), .fill_cnt(cnt4)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       en, mode, flush, iv;
      logic [3:0] din;
      logic [7:0] taps;
      logic [1:0] tv;
      logic [1:0] cnt;
   } vec_t;

   vec_t      vecs[$];
   logic [7:0] sb[$];
   int        n4;

   initial begin
      // Reset held with garbage on every input
      rst = 1'b1;
      en = 1'b1; mode = 1'b0; flush = 1'b0; in_valid = 1'b1; data_in = 4'hF;
      en4 = 1'b1; mode4 = 1'b1; flush4 = 1'b0; iv4 = 1'b1; din4 = 8'hEE;
      #1;
      chk("rst_taps", 32'(taps), 0);
      chk("rst_tv", 32'(taps_valid), 0);
      chk("rst_cnt", 32'(fill_cnt), 0);
      chk("rst_taps4", taps4, 0);

      // Load something, then assert reset between edges
      @(negedge clk);
      rst = 1'b0; en4 = 1'b0;
      en = 1'b1; mode = 1'b0; in_valid = 1'b1; data_in = 4'hF;
      @(negedge clk);
      chk("pre_rst_taps", 32'(taps), 32'h0F);
      chk("pre_rst_cnt", 32'(fill_cnt), 1);
      en = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("async_rst_taps", 32'(taps), 0);
      chk("async_rst_tv", 32'(taps_valid), 0);
      chk("async_rst_cnt", 32'(fill_cnt), 0);
      @(negedge clk);
      rst = 1'b0;

      //            en    mode  flush iv    din    taps   tv     cnt
      // shift 0..7
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 8'h00, 2'b01, 2'd1});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 8'h01, 2'b11, 2'd2});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 4'h2, 8'h12, 2'b11, 2'd2});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 4'h3, 8'h23, 2'b11, 2'd2});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 4'h4, 8'h34, 2'b11, 2'd2});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 4'h5, 8'h45, 2'b11, 2'd2});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 4'h6, 8'h56, 2'b11, 2'd2});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 4'h7, 8'h67, 2'b11, 2'd2});
      // broadcast A
      vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 4'hA, 8'hAA, 2'b11, 2'd2});
      // flush, then bubble pattern with en low twice
      vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 4'hB, 8'h00, 2'b00, 2'd0});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 4'h3, 8'h03, 2'b01, 2'd1});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 8'h03, 2'b01, 2'd1});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 4'hE, 8'h03, 2'b01, 2'd1});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 4'h5, 8'h35, 2'b10, 2'd1});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 4'h9, 8'h59, 2'b01, 2'd1});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 8'h90, 2'b11, 2'd2});
      // flush wins over en on a full pipe
      vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 4'hC, 8'h00, 2'b00, 2'd0});

      for (int i = 0; i < vecs.size(); i++) begin
         en = vecs[i].en; mode = vecs[i].mode; flush = vecs[i].flush;
         in_valid = vecs[i].iv; data_in = vecs[i].din;
         @(negedge clk);
         chk($sformatf("v%0d_taps", i), 32'(taps), 32'(vecs[i].taps));
         chk($sformatf("v%0d_tv", i), 32'(taps_valid), 32'(vecs[i].tv));
         chk($sformatf("v%0d_cnt", i), 32'(fill_cnt), 32'(vecs[i].cnt));
         chk($sformatf("v%0d_dout", i), 32'(data_out), 32'(vecs[i].taps[7:4]));
         chk($sformatf("v%0d_ov", i), 32'(out_valid), 32'(vecs[i].tv[1]));
      end
      en = 1'b0; flush = 1'b0;

      // Deep instance: scoreboard over shift traffic, one disabled edge mid-fill
      n4 = 0;
      for (int i = 0; i < 7; i++) begin
         logic       e;
         logic [7:0] d;
         e = (i != 2);
         d = (i < 2) ? 8'(8'h11 * (i + 1)) : 8'(8'h11 * i);
         en4 = e; mode4 = 1'b0; flush4 = 1'b0; iv4 = 1'b1; din4 = e ? d : 8'hFF;
         if (e) begin
            sb.push_back(d);
            n4++;
         end
         @(negedge clk);
         chk($sformatf("d4_cnt%0d", i), 32'(cnt4), (n4 > 4) ? 4 : n4);
         chk($sformatf("d4_ov%0d", i), 32'(ov4), (n4 >= 4) ? 1 : 0);
         if (sb.size() == 4) chk($sformatf("d4_dout%0d", i), 32'(dout4), 32'(sb.pop_front()));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
